// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - pipeline stage register with valid/ready handshake and two-entry skid buffer
// in_ready comes only from registered state, so back-pressure never forms a combinational path upstream.
module pipe_skid_reg #(
  parameter int                DATA_W  = 96,
  parameter int                PC_W    = 30,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_valid;
  logic [PC_W-1:0]   main_pc;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [PC_W-1:0]   skid_pc;
  logic [DATA_W-1:0] skid_data;
  logic              push;
  logic              pop;

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid & ~stall;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_pc    = main_pc;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_valid <= 1'b0;
      main_pc    <= '0;
      main_data  <= NOP_VAL;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_data  <= NOP_VAL;
    end else if (!main_valid) begin
      if (push) begin
        main_valid <= 1'b1;
        main_pc    <= in_pc;
        main_data  <= in_data;
      end
    end else if (!skid_valid) begin
      if (push && pop) begin
        main_pc   <= in_pc;
        main_data <= in_data;
      end else if (push) begin
        skid_valid <= 1'b1;
        skid_pc    <= in_pc;
        skid_data  <= in_data;
      end else if (pop) begin
        // pc/data deliberately left holding the last entry
        main_valid <= 1'b0;
      end
    end else if (pop) begin
      // skid is older than anything upstream, so it always refills main first
      main_pc    <= skid_pc;
      main_data  <= skid_data;
      skid_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - directed table-driven bench for pipe_skid_reg
module tb_pipe_skid_reg;

  localparam int                DATA_W = 96;
  localparam int                PC_W   = 30;
  localparam logic [DATA_W-1:0] NOP    = 96'hBAD0_0000_0000_0000_DEAD_BEEF;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [DATA_W-1:0] in_data;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_skid_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .NOP_VAL(NOP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_data(in_data), .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_data(out_data), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            rst;
    logic            iv;
    logic [PC_W-1:0] ipc;
    logic            st;
    logic            fl;
    logic            ordy;
    logic            ir;
    logic            ov;
    logic [PC_W-1:0] opc;
    logic [1:0]      occ;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [DATA_W-1:0] mk(input logic [PC_W-1:0] p);
    return {64'hC0DE_0000_F00D_0000, 2'b00, p};
  endfunction

  task automatic add(input logic rst, input logic iv, input logic [PC_W-1:0] ipc,
                     input logic st, input logic fl, input logic ordy,
                     input logic ir, input logic ov, input logic [PC_W-1:0] opc,
                     input logic [1:0] occ);
    vec_t v;
    v = '{rst, iv, ipc, st, fl, ordy, ir, ov, opc, occ};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input logic ir, input logic ov,
                               input logic [PC_W-1:0] opc, input logic [1:0] occ);
    // pc 0 only ever appears after reset/flush, where the payload is NOP
    logic [DATA_W-1:0] exp_data;
    exp_data = (opc == '0) ? NOP : mk(opc);
    check("in_ready",  idx, DATA_W'(in_ready),  DATA_W'(ir));
    check("out_valid", idx, DATA_W'(out_valid), DATA_W'(ov));
    check("out_pc",    idx, DATA_W'(out_pc),    DATA_W'(opc));
    check("out_data",  idx, out_data,           exp_data);
    check("occupancy", idx, DATA_W'(occupancy), DATA_W'(occ));
  endtask

  initial begin
    //   rst iv  ipc    st fl ordy  ir ov opc    occ
    // streaming 0x10..0x17
    add(0, 1, 30'h10, 0, 0, 1,   1, 0, 30'h00, 0);
    for (int p = 'h11; p <= 'h17; p++)
      add(0, 1, PC_W'(p), 0, 0, 1, 1, 1, PC_W'(p - 1), 1);
    add(0, 0, 30'h00, 0, 0, 1,   1, 1, 30'h17, 1);
    add(0, 0, 30'h00, 0, 0, 1,   1, 0, 30'h17, 0);
    // back-pressure A/B/C
    add(0, 1, 30'h20, 0, 0, 0,   1, 0, 30'h17, 0);
    add(0, 1, 30'h21, 0, 0, 0,   1, 1, 30'h20, 1);
    add(0, 1, 30'h22, 0, 0, 0,   0, 1, 30'h20, 2);
    add(0, 1, 30'h22, 0, 0, 1,   0, 1, 30'h20, 2);
    add(0, 1, 30'h22, 0, 0, 1,   1, 1, 30'h21, 1);
    add(0, 0, 30'h00, 0, 0, 1,   1, 1, 30'h22, 1);
    add(0, 0, 30'h00, 0, 0, 0,   1, 0, 30'h22, 0);
    // stall with a push into skid
    add(0, 1, 30'h30, 0, 0, 1,   1, 0, 30'h22, 0);
    add(0, 0, 30'h00, 1, 0, 1,   1, 0, 30'h30, 1);
    add(0, 1, 30'h31, 1, 0, 1,   1, 0, 30'h30, 1);
    add(0, 0, 30'h00, 1, 0, 1,   0, 0, 30'h30, 2);
    add(0, 0, 30'h00, 0, 0, 1,   0, 1, 30'h30, 2);
    add(0, 0, 30'h00, 0, 0, 1,   1, 1, 30'h31, 1);
    add(0, 0, 30'h00, 0, 0, 0,   1, 0, 30'h31, 0);
    // flush in TWO while offering 0x40
    add(0, 1, 30'h41, 0, 0, 0,   1, 0, 30'h31, 0);
    add(0, 1, 30'h42, 0, 0, 0,   1, 1, 30'h41, 1);
    add(0, 1, 30'h40, 0, 1, 0,   0, 1, 30'h41, 2);
    add(0, 0, 30'h00, 0, 0, 1,   1, 0, 30'h00, 0);
    // flush in ONE drops the accepted-looking offer, out_valid not masked
    add(0, 1, 30'h50, 0, 0, 0,   1, 0, 30'h00, 0);
    add(0, 1, 30'h51, 0, 1, 1,   1, 1, 30'h50, 1);
    add(0, 0, 30'h00, 0, 0, 1,   1, 0, 30'h00, 0);
    // flush together with stall
    add(0, 1, 30'h60, 0, 0, 0,   1, 0, 30'h00, 0);
    add(0, 1, 30'h61, 1, 0, 1,   1, 0, 30'h60, 1);
    add(0, 1, 30'h62, 1, 1, 1,   0, 0, 30'h60, 2);
    // reset mid-stream at occupancy 2, then a fresh push
    add(0, 1, 30'h63, 0, 0, 0,   1, 0, 30'h00, 0);
    add(0, 1, 30'h64, 0, 0, 0,   1, 1, 30'h63, 1);
    add(1, 1, 30'h65, 0, 0, 0,   0, 1, 30'h63, 2);
    add(0, 1, 30'h66, 0, 0, 1,   1, 0, 30'h00, 0);
    add(0, 0, 30'h00, 0, 0, 1,   1, 1, 30'h66, 1);
    add(0, 0, 30'h00, 0, 0, 1,   1, 0, 30'h66, 0);

    // reset held two cycles while upstream offers an entry
    reset = 1'b1; in_valid = 1'b1; in_pc = 30'h99; in_data = mk(30'h99);
    stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_data = '0;
    #2;
    check_outputs(-1, 1'b1, 1'b0, 30'h00, 2'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset     = vecs[i].rst;
      in_valid  = vecs[i].iv;
      in_pc     = vecs[i].ipc;
      in_data   = mk(vecs[i].ipc);
      stall     = vecs[i].st;
      flush     = vecs[i].fl;
      out_ready = vecs[i].ordy;
      #2;
      check_outputs(i, vecs[i].ir, vecs[i].ov, vecs[i].opc, vecs[i].occ);
      @(posedge clk);
      #1;
    end

    // stall alone: out_valid drops while held, rises again without a clock edge
    in_valid = 1'b1; in_pc = 30'h70; in_data = mk(30'h70); out_ready = 1'b0;
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    stall = 1'b1;
    #1;
    check("stall_masks_valid", 100, DATA_W'(out_valid), DATA_W'(1'b0));
    stall = 1'b0;
    #1;
    check("unstall_valid", 101, DATA_W'(out_valid), DATA_W'(1'b1));
    check("unstall_pc", 101, DATA_W'(out_pc), DATA_W'(30'h70));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline-stage register with a valid/ready handshake and a two-entry skid buffer. It replaces the fixed-field, stall-only ID/EX style registers between pipeline stages. Any stage bundle (PC plus a packed control/data word) passes through it at full throughput. Back-pressure from the downstream stage is absorbed without a combinational ready path from output to input, and stall/flush control from the pipeline controller is kept.

## Interface
Parameters:
- DATA_W, 96, width of the packed stage payload (alu op, operands, mem op, ctrl op, dst addr, we, exp code, ...)
- PC_W, 30, width of the word-address PC carried with each entry
- NOP_VAL, {DATA_W{1'b0}}, payload value loaded on reset and flush; encodes NOP, write-disable and no-exception

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream entry is valid
- in_ready  out  1  stage can accept an entry this cycle
- in_pc  in  PC_W  upstream PC
- in_data  in  DATA_W  upstream payload
- stall  in  1  freeze the output side: no dequeue, out_valid forced low
- flush  in  1  discard all held entries and the entry offered this cycle
- out_valid  out  1  main entry is valid and not stalled
- out_ready  in  1  downstream accepts the entry
- out_pc  out  PC_W  main entry PC
- out_data  out  DATA_W  main entry payload
- occupancy  out  2  number of held entries, 0..2

## Operation
- Storage: main register (pc, data, valid) drives the outputs. Skid register (pc, data, valid) holds one overflow entry.
- State is encoded by the valid bits:
  - EMPTY: main and skid both invalid
  - ONE: main valid, skid invalid
  - TWO: main and skid both valid
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = ~skid_valid. It depends only on registered state, never on out_ready.
- out_valid = main_valid & ~stall.
- occupancy = main_valid + skid_valid.
- Transitions when flush=0:
  - EMPTY: push → ONE, main ← in.
  - ONE: push&pop → ONE, main ← in. push&~pop → TWO, skid ← in. pop&~push → EMPTY. Neither → hold.
  - TWO: pop → ONE, main ← skid, skid cleared. No pop → hold. No push is possible in TWO.
- Order is strictly FIFO: skid is always older than any newer input.
- Flush takes priority over stall and over push/pop:
  - Next state is EMPTY.
  - main and skid data ← NOP_VAL, pc ← 0.
  - The entry offered in the flush cycle is dropped.
  - out_valid may be high in the flush cycle. If out_ready is also high, the downstream may consume that entry; the block does not mask it.
- Stall with flush=0: pop is impossible, so only pushes are taken. EMPTY→ONE and ONE→TWO still occur. In TWO, in_ready=0.
- Popping to EMPTY leaves main pc/data holding their last values. Only valid clears.
- Unused skid pc/data hold their values and are not observed.

## Timing
- Reset (synchronous; reset high at an edge):
  - main_valid, skid_valid ← 0
  - data ← NOP_VAL, pc ← 0
  - Outputs after that edge: out_valid=0, in_ready=1, occupancy=0, out_pc=0, out_data=NOP_VAL
- Reset asserted mid-operation discards all entries exactly like flush. Reset has priority over flush.
- Latency: an entry pushed at edge N is presented at out_* in cycle N+1 when the block was EMPTY, or ONE with a simultaneous pop.
- Throughput is one entry per cycle with out_ready held high.
- A downstream stall of k cycles holds at most 2 entries. in_ready falls one cycle after the second entry is accepted.
- in_ready rises the cycle after the pop that empties skid. Upstream may then push in the same cycle that in_ready is high.
- No combinational path exists from out_ready or stall to in_ready.

## Test plan
- Reset: assert reset 2 cycles while in_valid=1 → out_valid=0, in_ready=1, occupancy=0, out_data=NOP_VAL, out_pc=0.
- Streaming: push pc=0x10..0x17, out_ready=1 → each pc appears one cycle after push, 8 consecutive out_valid cycles, occupancy stays 1.
- Back-pressure: push A(0x20), B(0x21), C(0x22) with out_ready=0 → occupancy 1 then 2. in_ready=0 after B, C held off. Raise out_ready → A, B, C emerge in order.
- Stall: block in ONE holding pc=0x30, stall=1 for 3 cycles with out_ready=1 → out_valid=0. A new push 0x31 goes to skid (occupancy=2). Release stall → 0x30 then 0x31.
- Flush in TWO while pushing 0x40 → next cycle occupancy=0, out_data=NOP_VAL, 0x40 never appears, in_ready=1.
- Flush and stall together, then reset mid-stream with occupancy=2 → EMPTY, NOP_VAL outputs, and the next push emerges one cycle later.
